// File: rtl/sequencer_fsm_if.sv
// sequencer_fsm_if: instruction handshake and datapath control bundle for sequencer_fsm
interface sequencer_fsm_if;
  logic       start;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       waiting;
  logic [1:0] reg_sel;
  logic       en_A;
  logic       en_B;
  logic       en_C;
  logic       en_status;
  logic       sel_A;
  logic       sel_B;
  logic [1:0] wb_sel;
  logic       w_en;
  logic       illegal;
  logic       halted;
  modport master (
    output start, opcode, op,
    input  waiting, reg_sel, en_A, en_B, en_C, en_status, sel_A, sel_B, wb_sel, w_en, illegal, halted
  );
  modport slave (
    input  start, opcode, op,
    output waiting, reg_sel, en_A, en_B, en_C, en_status, sel_A, sel_B, wb_sel, w_en, illegal, halted
  );
endinterface

// File: rtl/sequencer_fsm.sv
// sequencer_fsm: multicycle Moore control FSM for the Simple RISC Machine datapath
module sequencer_fsm (
  input logic           clk,
  input logic           rst_n,
  sequencer_fsm_if.slave bus
);
  typedef enum logic [2:0] {
    S_WAIT, S_LOAD_A, S_LOAD_B, S_CALC, S_CMP, S_WR_REG, S_WR_IMM, S_HALT
  } state_t;
  state_t     state, state_nx;
  logic [4:0] ins, ins_nx;
  logic       ill, ill_nx;
  // state, latched instruction and illegal flag; async reset abandons any instruction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_WAIT;
      ins   <= '0;
      ill   <= 1'b0;
    end else begin
      state <= state_nx;
      ins   <= ins_nx;
      ill   <= ill_nx;
    end
  // next state: first step decoded from live inputs on accept, later steps from the latched copy
  always_comb begin
    state_nx = state;
    ins_nx   = ins;
    ill_nx   = 1'b0;
    case (state)
      S_WAIT:
        if (bus.start) begin
          ins_nx = {bus.opcode, bus.op};
          casez ({bus.opcode, bus.op})
            5'b110_10:            state_nx = S_WR_IMM;
            5'b110_00, 5'b101_11: state_nx = S_LOAD_B;
            5'b101_0?, 5'b101_10: state_nx = S_LOAD_A;
            5'b111_??:            state_nx = S_HALT;
            default:              ill_nx   = 1'b1;
          endcase
        end
      S_LOAD_A: state_nx = S_LOAD_B;
      S_LOAD_B: state_nx = (ins == 5'b101_01) ? S_CMP : S_CALC;
      S_CALC:   state_nx = S_WR_REG;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_WAIT;
    endcase
  end
  assign bus.waiting   = state == S_WAIT;
  assign bus.reg_sel   = (state == S_LOAD_A || state == S_WR_IMM) ? 2'b10 :
                         (state == S_WR_REG) ? 2'b01 : 2'b00;
  assign bus.en_A      = state == S_LOAD_A;
  assign bus.en_B      = state == S_LOAD_B;
  assign bus.en_C      = state == S_CALC;
  assign bus.en_status = state == S_CMP;
  assign bus.sel_A     = state == S_CALC && (ins == 5'b110_00 || ins == 5'b101_11);
  assign bus.sel_B     = 1'b0;
  assign bus.wb_sel    = (state == S_WR_IMM) ? 2'b10 : 2'b00;
  assign bus.w_en      = state == S_WR_REG || state == S_WR_IMM;
  assign bus.illegal   = ill;
  assign bus.halted    = state == S_HALT;
endmodule

// File: tb/tb_sequencer_fsm.sv
// tb_sequencer_fsm: directed per-scenario vector tables with expected control words
module tb_sequencer_fsm;
  logic clk;
  logic rst_n;
  sequencer_fsm_if bus();
  sequencer_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int fails = 0;

  // {waiting, reg_sel, en_A, en_B, en_C, en_status, sel_A, sel_B, wb_sel, w_en, illegal, halted}
  localparam logic [13:0] O_WAIT = 14'b1_00_0_0_0_0_0_0_00_0_0_0;
  localparam logic [13:0] O_LA   = 14'b0_10_1_0_0_0_0_0_00_0_0_0;
  localparam logic [13:0] O_LB   = 14'b0_00_0_1_0_0_0_0_00_0_0_0;
  localparam logic [13:0] O_CALC = 14'b0_00_0_0_1_0_0_0_00_0_0_0;
  localparam logic [13:0] O_CALZ = 14'b0_00_0_0_1_0_1_0_00_0_0_0;
  localparam logic [13:0] O_CMP  = 14'b0_00_0_0_0_1_0_0_00_0_0_0;
  localparam logic [13:0] O_WRR  = 14'b0_01_0_0_0_0_0_0_00_1_0_0;
  localparam logic [13:0] O_WRI  = 14'b0_10_0_0_0_0_0_0_10_1_0_0;
  localparam logic [13:0] O_HLT  = 14'b0_00_0_0_0_0_0_0_00_0_0_1;
  localparam logic [13:0] O_ILL  = 14'b1_00_0_0_0_0_0_0_00_0_1_0;

  typedef struct packed {
    logic        s;
    logic [2:0]  oc;
    logic [1:0]  op;
    logic [13:0] e;
  } vec_t;

  logic [13:0] outs;
  assign outs = {bus.waiting, bus.reg_sel, bus.en_A, bus.en_B, bus.en_C, bus.en_status,
                 bus.sel_A, bus.sel_B, bus.wb_sel, bus.w_en, bus.illegal, bus.halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    bus.start = 1'b0; bus.opcode = 3'b000; bus.op = 2'b00;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (outs !== O_WAIT) begin fails++; $display("FAIL reset_held: got %b expected %b", outs, O_WAIT); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (outs !== O_WAIT) begin fails++; $display("FAIL reset_release: got %b expected %b", outs, O_WAIT); end
  endtask

  task automatic test_mov_imm;
    vec_t v [2] = '{'{1'b1, 3'b110, 2'b10, O_WRI}, '{1'b0, 3'b000, 2'b00, O_WAIT}};
    foreach (v[i]) begin
      bus.start = v[i].s; bus.opcode = v[i].oc; bus.op = v[i].op;
      @(posedge clk); #1;
      checks++;
      if (outs !== v[i].e) begin fails++; $display("FAIL mov_imm[%0d]: got %b expected %b", i, outs, v[i].e); end
    end
  endtask

  task automatic test_add;
    vec_t v [5] = '{'{1'b1, 3'b101, 2'b00, O_LA}, '{1'b0, 3'b000, 2'b00, O_LB},
                    '{1'b0, 3'b000, 2'b00, O_CALC}, '{1'b0, 3'b000, 2'b00, O_WRR},
                    '{1'b0, 3'b000, 2'b00, O_WAIT}};
    foreach (v[i]) begin
      bus.start = v[i].s; bus.opcode = v[i].oc; bus.op = v[i].op;
      @(posedge clk); #1;
      checks++;
      if (outs !== v[i].e) begin fails++; $display("FAIL add[%0d]: got %b expected %b", i, outs, v[i].e); end
    end
  endtask

  task automatic test_cmp_mvn;
    vec_t v [8] = '{'{1'b1, 3'b101, 2'b01, O_LA}, '{1'b0, 3'b110, 2'b00, O_LB},
                    '{1'b0, 3'b110, 2'b00, O_CMP}, '{1'b0, 3'b000, 2'b00, O_WAIT},
                    '{1'b1, 3'b101, 2'b11, O_LB}, '{1'b0, 3'b101, 2'b00, O_CALZ},
                    '{1'b0, 3'b000, 2'b00, O_WRR}, '{1'b0, 3'b000, 2'b00, O_WAIT}};
    foreach (v[i]) begin
      bus.start = v[i].s; bus.opcode = v[i].oc; bus.op = v[i].op;
      @(posedge clk); #1;
      checks++;
      if (outs !== v[i].e) begin fails++; $display("FAIL cmp_mvn[%0d]: got %b expected %b", i, outs, v[i].e); end
    end
  endtask

  task automatic test_back_to_back;
    vec_t v [12] = '{'{1'b1, 3'b110, 2'b10, O_WRI}, '{1'b1, 3'b110, 2'b00, O_WAIT},
                     '{1'b1, 3'b110, 2'b00, O_LB}, '{1'b1, 3'b101, 2'b00, O_CALZ},
                     '{1'b1, 3'b101, 2'b00, O_WRR}, '{1'b1, 3'b101, 2'b00, O_WAIT},
                     '{1'b1, 3'b101, 2'b00, O_LA}, '{1'b1, 3'b110, 2'b10, O_LB},
                     '{1'b1, 3'b110, 2'b10, O_CALC}, '{1'b1, 3'b110, 2'b10, O_WRR},
                     '{1'b0, 3'b000, 2'b00, O_WAIT}, '{1'b0, 3'b000, 2'b00, O_WAIT}};
    foreach (v[i]) begin
      bus.start = v[i].s; bus.opcode = v[i].oc; bus.op = v[i].op;
      @(posedge clk); #1;
      checks++;
      if (outs !== v[i].e) begin fails++; $display("FAIL back_to_back[%0d]: got %b expected %b", i, outs, v[i].e); end
    end
  endtask

  task automatic test_illegal;
    vec_t v [5] = '{'{1'b1, 3'b011, 2'b00, O_ILL}, '{1'b0, 3'b011, 2'b00, O_WAIT},
                    '{1'b1, 3'b110, 2'b01, O_ILL}, '{1'b1, 3'b000, 2'b11, O_ILL},
                    '{1'b0, 3'b000, 2'b00, O_WAIT}};
    foreach (v[i]) begin
      bus.start = v[i].s; bus.opcode = v[i].oc; bus.op = v[i].op;
      @(posedge clk); #1;
      checks++;
      if (outs !== v[i].e) begin fails++; $display("FAIL illegal[%0d]: got %b expected %b", i, outs, v[i].e); end
    end
  endtask

  task automatic test_halt;
    bus.start = 1'b1; bus.opcode = 3'b111; bus.op = 2'b01;
    @(posedge clk); #1;
    bus.opcode = 3'b110; bus.op = 2'b10;
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (outs !== O_HLT) begin fails++; $display("FAIL halt[%0d]: got %b expected %b", i, outs, O_HLT); end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== O_WAIT) begin fails++; $display("FAIL halt_reset: got %b expected %b", outs, O_WAIT); end
    @(posedge clk); #3 rst_n = 1'b1;
  endtask

  task automatic test_async_reset;
    vec_t v [4] = '{'{1'b0, 3'b000, 2'b00, O_WAIT}, '{1'b0, 3'b000, 2'b00, O_WAIT},
                    '{1'b0, 3'b000, 2'b00, O_WAIT}, '{1'b0, 3'b000, 2'b00, O_WAIT}};
    vec_t w [2] = '{'{1'b1, 3'b110, 2'b10, O_WRI}, '{1'b0, 3'b000, 2'b00, O_WAIT}};
    bus.start = 1'b1; bus.opcode = 3'b101; bus.op = 2'b00;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (outs !== O_LA) begin fails++; $display("FAIL async_la: got %b expected %b", outs, O_LA); end
    @(posedge clk); #1;
    checks++;
    if (outs !== O_LB) begin fails++; $display("FAIL async_lb: got %b expected %b", outs, O_LB); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== O_WAIT) begin fails++; $display("FAIL async_drop: got %b expected %b", outs, O_WAIT); end
    @(posedge clk); #3 rst_n = 1'b1;
    foreach (v[i]) begin
      bus.start = v[i].s; bus.opcode = v[i].oc; bus.op = v[i].op;
      @(posedge clk); #1;
      checks++;
      if (outs !== v[i].e) begin fails++; $display("FAIL async_after[%0d]: got %b expected %b", i, outs, v[i].e); end
    end
    foreach (w[i]) begin
      bus.start = w[i].s; bus.opcode = w[i].oc; bus.op = w[i].op;
      @(posedge clk); #1;
      checks++;
      if (outs !== w[i].e) begin fails++; $display("FAIL async_resume[%0d]: got %b expected %b", i, outs, w[i].e); end
    end
  endtask

  initial begin
    test_reset;
    test_mov_imm;
    test_add;
    test_cmp_mvn;
    test_back_to_back;
    test_illegal;
    test_halt;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
